// File: rtl/alu_issue_queue_if.sv
// Request and result channels of the ALU issue queue.
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high; once valid is raised, the payload stays
// stable and valid stays high until that transfer.
interface alu_issue_queue_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) ();
   // request channel (dispatch -> queue)
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_opcode;
   logic [TAG_W-1:0] in_tag;

   // result channel (queue -> writeback)
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;

   modport master (
      output in_valid, in_a, in_b, in_opcode, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag, out_illegal
   );

   modport slave (
      input  in_valid, in_a, in_b, in_opcode, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag, out_illegal
   );
endinterface

// File: rtl/alu_issue_queue.sv
// In-order request FIFO in front of a combinational ALU, with a registered
// result stage (result, tag, illegal-opcode flag) and a saturating count of
// delivered results.
module alu_issue_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_issue_queue_if.slave  io,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [2:0]        alu_opcode,
   input  logic [WIDTH-1:0]  alu_result,
   output logic [31:0]       ops_done
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_GT  = 3'b010;

   // FIFO storage and pointers
   logic [WIDTH-1:0] mem_a_q   [DEPTH];
   logic [WIDTH-1:0] mem_a_d   [DEPTH];
   logic [WIDTH-1:0] mem_b_q   [DEPTH];
   logic [WIDTH-1:0] mem_b_d   [DEPTH];
   logic [2:0]       mem_op_q  [DEPTH];
   logic [2:0]       mem_op_d  [DEPTH];
   logic [TAG_W-1:0] mem_tag_q [DEPTH];
   logic [TAG_W-1:0] mem_tag_d [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // result register
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_result_q, out_result_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic             out_illegal_q, out_illegal_d;
   logic [31:0]      ops_done_q, ops_done_d;

   logic             empty;
   logic             in_rdy;
   logic             push;
   logic             cap;
   logic             fire;
   logic [WIDTH-1:0] head_a;
   logic [WIDTH-1:0] head_b;
   logic [2:0]       head_op;
   logic [TAG_W-1:0] head_tag;
   logic             head_illegal;

   // Handshake qualifiers and head-of-queue decode. in_ready depends only on
   // registered occupancy (and reset), never on out_ready.
   always_comb begin
      empty        = (count_q == '0);
      in_rdy       = rst_n && (count_q != FULL_CNT);
      push         = io.in_valid && in_rdy;
      cap          = !empty && (!out_valid_q || io.out_ready);
      fire         = out_valid_q && io.out_ready;
      head_a       = mem_a_q[rd_ptr_q];
      head_b       = mem_b_q[rd_ptr_q];
      head_op      = mem_op_q[rd_ptr_q];
      head_tag     = mem_tag_q[rd_ptr_q];
      head_illegal = (head_op != OP_SUB) && (head_op != OP_GT);
   end

   // Drive the ALU from the head entry; park it at zero when the queue is empty.
   always_comb begin
      alu_a      = '0;
      alu_b      = '0;
      alu_opcode = 3'b000;
      if (!empty) begin
         alu_a      = head_a;
         alu_b      = head_b;
         alu_opcode = head_op;
      end
   end

   // FIFO next state: write at wr_ptr on push, advance rd_ptr on capture.
   always_comb begin
      mem_a_d   = mem_a_q;
      mem_b_d   = mem_b_q;
      mem_op_d  = mem_op_q;
      mem_tag_d = mem_tag_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push) begin
         mem_a_d[wr_ptr_q]   = io.in_a;
         mem_b_d[wr_ptr_q]   = io.in_b;
         mem_op_d[wr_ptr_q]  = io.in_opcode;
         mem_tag_d[wr_ptr_q] = io.in_tag;
         wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (cap) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, cap})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Result register next state and saturating delivered-result counter.
   always_comb begin
      out_valid_d   = out_valid_q;
      out_result_d  = out_result_q;
      out_tag_d     = out_tag_q;
      out_illegal_d = out_illegal_q;
      ops_done_d    = ops_done_q;
      if (cap) begin
         out_valid_d   = 1'b1;
         out_result_d  = alu_result;
         out_tag_d     = head_tag;
         out_illegal_d = head_illegal;
      end else if (fire) begin
         out_valid_d = 1'b0;
      end
      if (fire && (ops_done_q != 32'hFFFF_FFFF)) begin
         ops_done_d = ops_done_q + 32'd1;
      end
   end

   // State registers; reset discards every queued and in-flight request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_a_q[i]   <= '0;
            mem_b_q[i]   <= '0;
            mem_op_q[i]  <= '0;
            mem_tag_q[i] <= '0;
         end
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_tag_q     <= '0;
         out_illegal_q <= 1'b0;
         ops_done_q    <= '0;
      end else begin
         mem_a_q       <= mem_a_d;
         mem_b_q       <= mem_b_d;
         mem_op_q      <= mem_op_d;
         mem_tag_q     <= mem_tag_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         out_valid_q   <= out_valid_d;
         out_result_q  <= out_result_d;
         out_tag_q     <= out_tag_d;
         out_illegal_q <= out_illegal_d;
         ops_done_q    <= ops_done_d;
      end
   end

   assign io.in_ready    = in_rdy;
   assign io.out_valid   = out_valid_q;
   assign io.out_result  = out_result_q;
   assign io.out_tag     = out_tag_q;
   assign io.out_illegal = out_illegal_q;
   assign ops_done       = ops_done_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: a behavioural ALU closes the loop, and
// every observation is checked against hand-computed values.
module tb_alu_issue_queue;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_opcode;
   logic [WIDTH-1:0] alu_result;
   logic [31:0]      ops_done;

   int checks = 0;
   int errors = 0;

   alu_issue_queue_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) io ();

   alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .io         (io),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_opcode (alu_opcode),
      .alu_result (alu_result),
      .ops_done   (ops_done)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural ALU: sub, unsigned greater-than, zero for anything else
   always_comb begin
      alu_result = '0;
      case (alu_opcode)
         3'b001:  alu_result = alu_a - alu_b;
         3'b010:  alu_result = {{(WIDTH-1){1'b0}}, (alu_a > alu_b)};
         default: alu_result = '0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Present one request and hold it until accepted; returns just after the accepting edge.
   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [3:0] tag);
      int w = 0;
      io.in_valid  = 1'b1;
      io.in_a      = a;
      io.in_b      = b;
      io.in_opcode = op;
      io.in_tag    = tag;
      @(negedge clk);
      while (!io.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("push_accept", {31'd0, io.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      io.in_valid = 1'b0;
   endtask

   // Wait (bounded) for a result, check it, and let it be consumed by the next edge.
   task automatic expect_out(input string name, input logic [31:0] res, input logic [3:0] tag,
                             input logic ill);
      int w = 0;
      @(negedge clk);
      while (!io.out_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({name, "_valid"}, {31'd0, io.out_valid}, 32'd1);
      chk({name, "_result"}, io.out_result, res);
      chk({name, "_tag"}, {28'd0, io.out_tag}, {28'd0, tag});
      chk({name, "_illegal"}, {31'd0, io.out_illegal}, {31'd0, ill});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      io.in_valid  = 1'b0;
      io.in_a      = '0;
      io.in_b      = '0;
      io.in_opcode = '0;
      io.in_tag    = '0;
      io.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   logic [3:0] t;

   initial begin
      // ---- 1: reset state and first operation latency ----
      rst_n        = 1'b0;
      io.in_valid  = 1'b0;
      io.in_a      = '0;
      io.in_b      = '0;
      io.in_opcode = '0;
      io.in_tag    = '0;
      io.out_ready = 1'b1;
      #2;
      chk("rst_in_ready", {31'd0, io.in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
      chk("rst_out_result", io.out_result, 32'd0);
      chk("rst_ops_done", ops_done, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, io.in_ready}, 32'd1);
      @(posedge clk);
      #1;

      push(32'd10, 32'd3, 3'b001, 4'd5);
      @(negedge clk);
      chk("t1_valid_after_1", {31'd0, io.out_valid}, 32'd0);
      chk("t1_alu_a_head", alu_a, 32'd10);
      chk("t1_alu_op_head", {29'd0, alu_opcode}, 32'd1);
      @(negedge clk);
      chk("t1_valid_after_2", {31'd0, io.out_valid}, 32'd1);
      chk("t1_result", io.out_result, 32'd7);
      chk("t1_tag", {28'd0, io.out_tag}, 32'd5);
      chk("t1_illegal", {31'd0, io.out_illegal}, 32'd0);
      chk("t1_ops_before", ops_done, 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t1_ops_after", ops_done, 32'd1);
      chk("t1_valid_drop", {31'd0, io.out_valid}, 32'd0);
      chk("t1_tag_hold", {28'd0, io.out_tag}, 32'd5);
      chk("t1_result_hold", io.out_result, 32'd7);
      chk("t1_alu_a_empty", alu_a, 32'd0);
      @(posedge clk);
      #1;

      // ---- 2: wraparound sub and unsigned compare ----
      push(32'd0, 32'd1, 3'b001, 4'd1);
      expect_out("t2_sub_wrap", 32'hFFFF_FFFF, 4'd1, 1'b0);
      push(32'd5, 32'd3, 3'b010, 4'd2);
      expect_out("t2_gt_true", 32'd1, 4'd2, 1'b0);
      push(32'd3, 32'd5, 3'b010, 4'd3);
      expect_out("t2_gt_false", 32'd0, 4'd3, 1'b0);
      @(negedge clk);
      chk("t2_ops", ops_done, 32'd4);
      @(posedge clk);
      #1;

      // ---- 3: backpressure fills the FIFO, then drains in order ----
      io.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         t = 4'(10 + i);
         push({27'd0, t, 1'b0}, {28'd0, t}, 3'b001, t);
      end
      io.in_valid  = 1'b1;
      io.in_a      = 32'd30;
      io.in_b      = 32'd15;
      io.in_opcode = 3'b001;
      io.in_tag    = 4'd15;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_full_in_ready", {31'd0, io.in_ready}, 32'd0);
         chk("t3_stall_valid", {31'd0, io.out_valid}, 32'd1);
         chk("t3_stall_tag", {28'd0, io.out_tag}, 32'd10);
         chk("t3_stall_result", io.out_result, 32'd10);
         @(posedge clk);
         #1;
      end
      io.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t3_drain_valid", {31'd0, io.out_valid}, 32'd1);
         chk("t3_drain_tag", {28'd0, io.out_tag}, 32'(10 + k));
         chk("t3_drain_result", io.out_result, 32'(10 + k));
         @(posedge clk);
         #1;
         if (k == 1) io.in_valid = 1'b0;
      end
      @(negedge clk);
      chk("t3_drained", {31'd0, io.out_valid}, 32'd0);
      chk("t3_ops", ops_done, 32'd10);
      @(posedge clk);
      #1;

      // ---- 4: back-to-back stream with pointer wrap ----
      do_reset();
      @(posedge clk);
      #1;
      for (int c = 0; c < 13; c++) begin
         io.in_valid  = (c < 10);
         io.in_a      = 32'h1000 + 32'(c * 5);
         io.in_b      = 32'(c);
         io.in_opcode = 3'b001;
         io.in_tag    = 4'(c);
         @(negedge clk);
         if (c < 10) chk("t4_in_ready", {31'd0, io.in_ready}, 32'd1);
         if (c >= 2 && c <= 11) begin
            chk("t4_valid", {31'd0, io.out_valid}, 32'd1);
            chk("t4_tag", {28'd0, io.out_tag}, 32'(c - 2));
            chk("t4_result", io.out_result, 32'h1000 + 32'((c - 2) * 4));
         end else begin
            chk("t4_idle", {31'd0, io.out_valid}, 32'd0);
         end
         @(posedge clk);
         #1;
      end
      io.in_valid = 1'b0;
      @(negedge clk);
      chk("t4_ops", ops_done, 32'd10);
      @(posedge clk);
      #1;

      // ---- 5: illegal opcode flag, cleared by the next legal op ----
      push(32'd9, 32'd2, 3'b111, 4'd3);
      expect_out("t5_illegal", 32'd0, 4'd3, 1'b1);
      push(32'd4, 32'd1, 3'b001, 4'd4);
      expect_out("t5_legal", 32'd3, 4'd4, 1'b0);
      @(negedge clk);
      chk("t5_ops", ops_done, 32'd12);
      @(posedge clk);
      #1;

      // ---- 6: asynchronous reset with work in flight ----
      io.out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         push(32'(20 + i), 32'(i), 3'b001, 4'(i));
      end
      @(negedge clk);
      chk("t6_pre_valid", {31'd0, io.out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", {31'd0, io.out_valid}, 32'd0);
      chk("t6_async_ops", ops_done, 32'd0);
      chk("t6_async_in_ready", {31'd0, io.in_ready}, 32'd0);
      chk("t6_async_tag", {28'd0, io.out_tag}, 32'd0);
      io.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t6_no_stale", {31'd0, io.out_valid}, 32'd0);
         chk("t6_in_ready", {31'd0, io.in_ready}, 32'd1);
      end
      @(posedge clk);
      #1;
      push(32'd7, 32'd2, 3'b001, 4'd9);
      expect_out("t6_fresh", 32'd5, 4'd9, 1'b0);
      @(negedge clk);
      chk("t6_ops", ops_done, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
Request buffer and result-capture stage around the 32-bit combinational ALU.
- Accepts tagged operation requests (A, B, opcode) over a valid/ready interface and queues them in an in-order FIFO.
- Drives the FIFO head onto the ALU operand/opcode inputs.
- Registers the ALU result with its tag on a valid/ready output interface.
- Sits between the instruction decode/dispatch logic and the ALU, and presents registered results to writeback.

Parameters:
WIDTH, 32, operand/result width; must match the ALU.
DEPTH, 4, FIFO entries; power of two, ≥2.
TAG_W, 4, request tag width; tag passes through unchanged.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous assert, active low.
in_valid  input  1  request valid.
in_ready  output  1  request accepted when in_valid && in_ready.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_opcode  input  3  operation; 3'b001 = sub, 3'b010 = unsigned A>B; all others illegal.
in_tag  input  TAG_W  request tag.
alu_a  output  WIDTH  to ALU A.
alu_b  output  WIDTH  to ALU B.
alu_opcode  output  3  to ALU opcode.
alu_result  input  WIDTH  from ALU result; combinational from alu_*.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts when out_valid && out_ready.
out_result  output  WIDTH  registered ALU result.
out_tag  output  TAG_W  tag of that result.
out_illegal  output  1  opcode of that result was not 001/010.
ops_done  output  32  count of completed output handshakes; saturates at 32'hFFFFFFFF.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty; rd/wr pointers and count = 0.
  - out_valid = 0; out_result = 0; out_tag = 0; out_illegal = 0; ops_done = 0.
  - in_ready = 0 while rst_n low.
  - All in-flight requests are discarded, including a reset asserted mid-operation.
- FIFO:
  - in_ready = (count != DEPTH), registered-state based; no combinational path from out_ready to in_ready.
  - A push writes {a, b, opcode, tag} at wr_ptr; pointers wrap modulo DEPTH.
  - No push when full, even if a pop happens the same cycle.
- ALU drive:
  - FIFO non-empty: alu_a/alu_b/alu_opcode = head entry, combinationally.
  - FIFO empty: alu_a = 0, alu_b = 0, alu_opcode = 3'b000.
- Capture condition, cap = !empty && (!out_valid || out_ready). On cap at the clock edge:
  - out_result <= alu_result; out_tag <= head tag; out_illegal <= (head opcode not in {001, 010}); out_valid <= 1.
  - The head is popped.
- If out_valid && out_ready && empty: out_valid <= 0. out_result, out_tag and out_illegal hold their values.
- While out_valid && !out_ready: out_* are stable and no capture occurs.
- Simultaneous push and pop: count unchanged.
- Latency and throughput:
  - A request accepted at edge k becomes the head no earlier than after edge k; no empty-FIFO bypass.
  - With an empty pipeline, out_valid rises after edge k+1, i.e. 2 cycles from acceptance.
  - Sustained throughput is 1 op/cycle with out_ready held high.
- Ordering: results leave strictly in request order; tags are never reordered.
- Arithmetic is done by the ALU; this block neither checks nor modifies result values.
  - sub wraps modulo 2^WIDTH.
  - gt result = 1 or 0, zero-extended.
  - Illegal opcodes yield 0 from the ALU and are flagged by out_illegal.
- ops_done increments on each out_valid && out_ready and holds at max.

Test Plan:
1. Reset release, in_a=10, in_b=3, opcode=001, tag=5, out_ready=1 -> 2 cycles after acceptance: out_valid=1, out_result=7, out_tag=5, out_illegal=0, ops_done=1.
2. in_a=0, in_b=1, opcode=001 -> out_result=32'hFFFFFFFF. Then a=5, b=3, opcode=010 -> out_result=1. Then a=3, b=5, opcode=010 -> out_result=0.
3. out_ready=0, push 5 requests at DEPTH=4:
   - 1 is captured in the output register and 4 fill the FIFO.
   - in_ready=0 at count=4; the 6th request stalls.
   - out_* stay stable while stalled.
   - Release out_ready -> all 5 drain in tag order, 1 per cycle.
4. 10 back-to-back requests, tags 0..9, out_ready=1 -> pointers wrap, results in order, one output per cycle after the first, ops_done=10.
5. opcode=3'b111, a=9, b=2 -> out_result=0, out_illegal=1. The next legal op clears out_illegal.
6. Assert rst_n low with 3 entries queued and out_valid=1 -> asynchronously out_valid=0 and ops_done=0. After release, no stale result appears and in_ready=1.
